// File: rtl/mmio_responder_if.sv
// Data-memory port bundle between the processor memory stage and the MMIO responder.
interface mmio_responder_if;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_mmio;
   logic        hit;
   logic        irq;

   modport master (output address_dmem, data, wren, input q_mmio, hit, irq);
   modport slave  (input address_dmem, data, wren, output q_mmio, hit, irq);
endinterface

// File: rtl/mmio_responder.sv
// Word-addressed MMIO window: mailbox FIFO, 32-bit timer with compare match, sticky flags.
module mmio_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic              clock,
   input logic              reset,
   mmio_responder_if.slave  bus
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [31:0]   r_q;
   logic          r_hit;
   logic [31:0]   r_timer;
   logic [31:0]   r_cmp;
   logic          r_tmr_en;
   logic          r_irq_en;
   logic          r_ovf;
   logic          r_udf;
   logic          r_match;
   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [PW:0]   r_count;

   logic [31:0] w_off;
   logic        w_in;
   logic [2:0]  w_sel;
   logic        w_wr;
   logic        w_push;
   logic        w_pop;
   logic        w_twr;
   logic        w_cwr;
   logic        w_ctrlwr;
   logic        w_clr;
   logic        w_full;
   logic        w_empty;
   logic [31:0] w_timer_next;
   logic        w_match_set;
   logic        w_ovf_set;
   logic        w_udf_set;
   logic [31:0] w_rdata;

   // In-window iff the unsigned offset fits in 3 bits; wraps below BASE_ADDR fall out naturally.
   assign w_off    = bus.address_dmem - BASE_ADDR;
   assign w_in     = (w_off[31:3] == 29'd0);
   assign w_sel    = w_off[2:0];
   assign w_wr     = bus.wren & w_in;
   assign w_push   = w_wr & (w_sel == 3'd1);
   assign w_twr    = w_wr & (w_sel == 3'd2);
   assign w_cwr    = w_wr & (w_sel == 3'd3);
   assign w_ctrlwr = w_wr & (w_sel == 3'd4);
   assign w_pop    = w_wr & (w_sel == 3'd5);
   assign w_clr    = w_ctrlwr & bus.data[1];

   assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);

   assign w_timer_next = w_twr ? bus.data : (r_tmr_en ? r_timer + 32'd1 : r_timer);
   assign w_match_set  = (w_twr & (bus.data == r_cmp)) | (r_tmr_en & (w_timer_next == r_cmp));
   assign w_ovf_set    = w_push & w_full;
   assign w_udf_set    = w_pop & w_empty;

   always_comb begin
      w_rdata = '0;
      case (w_sel)
         3'd0: w_rdata = {16'd0, 8'(r_count), 3'd0, r_match, r_udf, r_ovf, w_full, w_empty};
         3'd1: w_rdata = w_empty ? '0 : r_mem[r_head];
         3'd2: w_rdata = r_timer;
         3'd3: w_rdata = r_cmp;
         3'd4: w_rdata = {29'd0, r_irq_en, 1'b0, r_tmr_en};
         default: w_rdata = '0;
      endcase
   end

   // FIFO storage needs no reset: pointers and count alone define which entries are live.
   always_ff @(posedge clock) begin
      if (w_push && !w_full) r_mem[r_tail] <= bus.data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q      <= '0;
         r_hit    <= 1'b0;
         r_timer  <= '0;
         r_cmp    <= '0;
         r_tmr_en <= 1'b0;
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_match  <= 1'b0;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
      end else begin
         r_hit <= w_in & ~bus.wren;
         r_q   <= (w_in && !bus.wren) ? w_rdata : '0;

         r_timer <= w_timer_next;
         if (w_cwr) r_cmp <= bus.data;
         if (w_ctrlwr) begin
            r_tmr_en <= bus.data[0];
            r_irq_en <= bus.data[2];
         end

         if (w_push && !w_full) begin
            r_tail  <= r_tail + 1'b1;
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_empty) begin
            r_head  <= r_head + 1'b1;
            r_count <= r_count - 1'b1;
         end

         // Set events take priority over a same-cycle clear.
         r_ovf   <= w_ovf_set   | (r_ovf   & ~w_clr);
         r_udf   <= w_udf_set   | (r_udf   & ~w_clr);
         r_match <= w_match_set | (r_match & ~w_clr);
      end
   end

   assign bus.q_mmio = r_q;
   assign bus.hit    = r_hit;
   assign bus.irq    = r_match & r_irq_en;
endmodule

// File: tb/tb_mmio_responder.sv
// Directed vector bench for mmio_responder: FIFO, timer/compare, decode, flags and async reset.
module tb_mmio_responder;
   localparam logic [31:0] BASE = 32'h0000_1000;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] d;
      logic [31:0] q;
      logic        h;
      logic        irq;
   } vec_t;

   logic clock;
   logic reset;
   int   total;
   int   bad;
   vec_t vecs[$];

   mmio_responder_if bus ();

   mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      bus.wren         = we;
      bus.address_dmem = a;
      bus.data         = d;
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [2:0] off, input logic [31:0] q, input logic irq);
      vecs.push_back('{1'b0, BASE + 32'(off), 32'd0, q, 1'b1, irq});
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic irq);
      vecs.push_back('{1'b1, BASE + 32'(off), d, 32'd0, 1'b0, irq});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.wren = 1'b0;
      bus.address_dmem = '0;
      bus.data = '0;
      reset = 1'b1;

      // FIFO ordering and underflow
      rd(0, 32'h0000_0001, 0);
      rd(1, 32'h0, 0);
      wr(1, 32'hA, 0); wr(1, 32'hB, 0); wr(1, 32'hC, 0);
      rd(1, 32'hA, 0);
      rd(0, 32'h0000_0300, 0);
      wr(5, 0, 0);
      rd(1, 32'hB, 0);
      wr(5, 0, 0); wr(5, 0, 0);
      rd(0, 32'h0000_0001, 0);
      wr(5, 0, 0);
      rd(0, 32'h0000_0009, 0);
      wr(4, 32'h2, 0);
      rd(0, 32'h0000_0001, 0);
      rd(4, 32'h0, 0);
      // overflow and pointer wrap
      for (int i = 1; i <= 9; i++) wr(1, 32'(i), 0);
      rd(0, 32'h0000_0806, 0);
      rd(1, 32'h1, 0);
      for (int i = 0; i < 8; i++) wr(5, 0, 0);
      rd(0, 32'h0000_0005, 0);
      wr(1, 32'h55, 0);
      rd(1, 32'h55, 0);
      rd(1, 32'h55, 0);
      rd(0, 32'h0000_0104, 0);
      wr(4, 32'h2, 0);
      rd(0, 32'h0000_0100, 0);
      // decode: out-of-window, reserved, write-only, STATUS write ignored
      vecs.push_back('{1'b0, BASE - 32'd1, 32'd0, 32'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, BASE + 32'd8, 32'd0, 32'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, BASE + 32'd9, 32'h1234, 32'd0, 1'b0, 1'b0});
      rd(6, 32'h0, 0);
      rd(7, 32'h0, 0);
      rd(5, 32'h0, 0);
      wr(0, 32'hFFFF_FFFF, 0);
      rd(0, 32'h0000_0100, 0);
      // timer wrap and compare
      wr(2, 32'hFFFF_FFFE, 0);
      wr(3, 32'h1, 0);
      rd(3, 32'h1, 0);
      rd(2, 32'hFFFF_FFFE, 0);
      wr(4, 32'h5, 0);
      rd(2, 32'hFFFF_FFFE, 0);
      rd(2, 32'hFFFF_FFFF, 0);
      rd(2, 32'h0, 1);
      rd(2, 32'h1, 1);
      rd(0, 32'h0000_0110, 1);
      wr(4, 32'h7, 0);
      rd(0, 32'h0000_0100, 0);
      rd(4, 32'h5, 0);
      // TIMER write overrides increment
      wr(2, 32'h100, 0);
      rd(2, 32'h100, 0);
      rd(2, 32'h101, 0);
      // match set wins over same-cycle clear
      wr(3, 32'h105, 0);
      rd(4, 32'h5, 0);
      wr(4, 32'h7, 1);
      rd(0, 32'h0000_0110, 1);
      wr(4, 32'h7, 0);
      rd(0, 32'h0000_0100, 0);
      // TIMER write equal to compare sets match with timer disabled
      wr(4, 32'h4, 0);
      wr(2, 32'h105, 1);
      rd(0, 32'h0000_0110, 1);
      rd(2, 32'h105, 1);

      // reset-state checks
      #2;
      chk("rst_q", bus.q_mmio, 32'h0);
      chk("rst_hit", {31'd0, bus.hit}, 32'h0);
      chk("rst_irq", {31'd0, bus.irq}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         op(vecs[i].we, vecs[i].addr, vecs[i].d);
         chk($sformatf("v%0d_q", i), bus.q_mmio, vecs[i].q);
         chk($sformatf("v%0d_hit", i), {31'd0, bus.hit}, {31'd0, vecs[i].h});
         chk($sformatf("v%0d_irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].irq});
      end

      // asynchronous reset between edges with irq, hit and FIFO content live
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("async_q", bus.q_mmio, 32'h0);
      chk("async_hit", {31'd0, bus.hit}, 32'h0);
      chk("async_irq", {31'd0, bus.irq}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      op(1'b0, BASE, 32'd0);
      chk("post_status", bus.q_mmio, 32'h0000_0001);
      chk("post_hit", {31'd0, bus.hit}, 32'h1);
      op(1'b0, BASE + 32'd1, 32'd0);
      chk("post_head", bus.q_mmio, 32'h0);
      op(1'b0, BASE + 32'd2, 32'd0);
      chk("post_timer", bus.q_mmio, 32'h0);
      op(1'b0, BASE + 32'd3, 32'd0);
      chk("post_cmp", bus.q_mmio, 32'h0);
      op(1'b0, BASE + 32'd4, 32'd0);
      chk("post_ctrl", bus.q_mmio, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
